// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, router port numbering,
// flit field positions and FSM state encoding for the route stage.
package noc_pkg;

   typedef enum logic [1:0] {
      BODY     = 2'b00,
      HEAD     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_type_e;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_N     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_E     = 3;
   localparam int PORT_W     = 4;

   // Type field occupies the top TYPE_WIDTH bits; destination starts at bit DEST_LSB.
   localparam int TYPE_WIDTH = 2;
   localparam int DEST_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DROP
   } rc_state_e;

   function automatic logic is_head_type(input flit_type_e t);
      return (t == HEAD) || (t == HEADTAIL);
   endfunction

endpackage

// File: rtl/route_compute.sv
// Route-computation stage: looks up the output port on each head flit,
// tags the whole packet with it and forwards through a one-deep register.
module route_compute
   import noc_pkg::*;
#(
   parameter int NUM_ROWS       = 2,
   parameter int NUM_COLS       = 2,
   parameter int NUM_OUTPUTS    = 5,
   parameter int FLIT_WIDTH     = 32,
   parameter int CNT_WIDTH      = 16,
   parameter int ROUTE_WIDTH    = $clog2(NUM_OUTPUTS),
   parameter int RTR_ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS)
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [0:NUM_ROWS*NUM_COLS-1][ROUTE_WIDTH-1:0]      routing_table,
   input  logic [FLIT_WIDTH-1:0]                              in_flit,
   input  logic                                               in_valid,
   output logic                                               in_ready,
   output logic [FLIT_WIDTH-1:0]                              out_flit,
   output logic [ROUTE_WIDTH-1:0]                             out_port,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic                                               err_dest,
   output logic                                               err_proto,
   output logic [CNT_WIDTH-1:0]                               pkt_count
);

   localparam int NUM_DEST = NUM_ROWS * NUM_COLS;

   rc_state_e                 state;
   rc_state_e                 next_state;
   logic [ROUTE_WIDTH-1:0]    route;
   logic [ROUTE_WIDTH-1:0]    lookup;
   logic [ROUTE_WIDTH-1:0]    fwd_port;
   logic [RTR_ADDR_WIDTH-1:0] dest;
   flit_type_e                ftype;
   logic                      accept;
   logic                      head_like;
   logic                      dest_ok;
   logic                      fwd;
   logic                      head_fwd;
   logic                      load_route;
   logic                      err_d;
   logic                      err_p;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign ftype     = flit_type_e'(in_flit[FLIT_WIDTH-1 -: TYPE_WIDTH]);
   assign dest      = in_flit[DEST_LSB +: RTR_ADDR_WIDTH];
   assign head_like = is_head_type(ftype);
   assign dest_ok   = 32'(dest) < NUM_DEST;

   // Table read by comparison so an out-of-range address never indexes past the table.
   always_comb begin
      lookup = '0;
      for (int unsigned i = 0; i < NUM_DEST; i++) begin
         if (32'(dest) == i) lookup = routing_table[i];
      end
   end

   always_comb begin
      next_state = state;
      fwd        = 1'b0;
      fwd_port   = route;
      head_fwd   = 1'b0;
      load_route = 1'b0;
      err_d      = 1'b0;
      err_p      = 1'b0;
      if (accept) begin
         if (head_like) begin
            // A head outside IDLE closes the previous packet, then opens a new one.
            err_p = (state != ST_IDLE);
            if (dest_ok) begin
               fwd        = 1'b1;
               fwd_port   = lookup;
               head_fwd   = 1'b1;
               load_route = (ftype == HEAD);
               next_state = (ftype == HEAD) ? ST_ACTIVE : ST_IDLE;
            end else begin
               err_d      = 1'b1;
               next_state = (ftype == HEAD) ? ST_DROP : ST_IDLE;
            end
         end else begin
            unique case (state)
               ST_IDLE: begin
                  err_p = 1'b1;
               end
               ST_ACTIVE: begin
                  fwd = 1'b1;
                  if (ftype == TAIL) next_state = ST_IDLE;
               end
               ST_DROP: begin
                  if (ftype == TAIL) next_state = ST_IDLE;
               end
               default: next_state = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         route     <= ROUTE_WIDTH'(PORT_LOCAL);
         out_flit  <= '0;
         out_port  <= '0;
         out_valid <= 1'b0;
         err_dest  <= 1'b0;
         err_proto <= 1'b0;
         pkt_count <= '0;
      end else begin
         state     <= next_state;
         err_dest  <= err_d;
         err_proto <= err_p;
         if (load_route) route <= fwd_port;
         if (fwd) begin
            out_flit  <= in_flit;
            out_port  <= fwd_port;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (head_fwd) pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_route_compute.sv
// Bench for route_compute: packet-level reference model on a 2x2 instance,
// plus directed out-of-range destination cases on a 2x3 instance.
module tb_route_compute;
   import noc_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // ---------------- 2x2 instance ----------------
   logic              reset_a;
   logic [0:3][2:0]   rt_a;
   logic [31:0]       in_flit_a;
   logic              in_valid_a;
   logic              in_ready_a;
   logic [31:0]       out_flit_a;
   logic [2:0]        out_port_a;
   logic              out_valid_a;
   logic              out_ready_a;
   logic              err_dest_a;
   logic              err_proto_a;
   logic [15:0]       pkt_count_a;

   route_compute #(.NUM_ROWS(2), .NUM_COLS(2)) dut_a (
      .clk(clk), .reset(reset_a), .routing_table(rt_a),
      .in_flit(in_flit_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .out_flit(out_flit_a), .out_port(out_port_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .err_dest(err_dest_a), .err_proto(err_proto_a),
      .pkt_count(pkt_count_a)
   );

   // ---------------- 2x3 instance ----------------
   logic              reset_b;
   logic [0:5][2:0]   rt_b;
   logic [31:0]       in_flit_b;
   logic              in_valid_b;
   logic              in_ready_b;
   logic [31:0]       out_flit_b;
   logic [2:0]        out_port_b;
   logic              out_valid_b;
   logic              out_ready_b;
   logic              err_dest_b;
   logic              err_proto_b;
   logic [15:0]       pkt_count_b;

   route_compute #(.NUM_ROWS(2), .NUM_COLS(3)) dut_b (
      .clk(clk), .reset(reset_b), .routing_table(rt_b),
      .in_flit(in_flit_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .out_flit(out_flit_b), .out_port(out_port_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .err_dest(err_dest_b), .err_proto(err_proto_b),
      .pkt_count(pkt_count_b)
   );

   // ---------------- reference model (packet level) ----------------
   bit          m_in_pkt;
   bit          m_skip;
   int          m_pkt_port;
   bit          m_valid;
   logic [31:0] m_flit;
   int          m_port;
   bit          m_ed;
   bit          m_ep;
   int          m_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_a(input bit rst, input bit vld, input logic [31:0] f, input bit ordy);
      bit acc, fwd, delivered;
      int typ, dst, port;
      if (rst) begin
         m_in_pkt = 0; m_skip = 0; m_valid = 0; m_count = 0; m_ed = 0; m_ep = 0;
         m_flit = '0; m_port = 0;
         return;
      end
      acc       = vld && (!m_valid || ordy);
      delivered = m_valid && ordy;
      fwd  = 0;
      port = 0;
      m_ed = 0;
      m_ep = 0;
      if (acc) begin
         typ = int'(f[31:30]);
         dst = int'(f[1:0]);
         if (typ == 1 || typ == 3) begin
            if (m_in_pkt || m_skip) m_ep = 1;
            m_in_pkt = 0;
            m_skip   = 0;
            if (dst >= 4) begin
               m_ed   = 1;
               m_skip = (typ == 1);
            end else begin
               port       = int'(rt_a[dst]);
               fwd        = 1;
               m_count    = (m_count + 1) % 65536;
               m_in_pkt   = (typ == 1);
               m_pkt_port = port;
            end
         end else if (m_in_pkt) begin
            fwd  = 1;
            port = m_pkt_port;
            if (typ == 2) m_in_pkt = 0;
         end else if (m_skip) begin
            if (typ == 2) m_skip = 0;
         end else begin
            m_ep = 1;
         end
      end
      if (fwd) begin
         m_valid = 1; m_flit = f; m_port = port;
      end else if (delivered) begin
         m_valid = 0;
      end
   endtask

   task automatic tick_a(input bit rst, input bit vld, input logic [31:0] f, input bit ordy);
      reset_a = rst; in_valid_a = vld; in_flit_a = f; out_ready_a = ordy;
      model_a(rst, vld, f, ordy);
      @(posedge clk);
      #1;
      chk("a_out_valid", 32'(out_valid_a), 32'(m_valid));
      if (m_valid) begin
         chk("a_out_flit", out_flit_a, m_flit);
         chk("a_out_port", 32'(out_port_a), 32'(m_port));
      end
      chk("a_in_ready", 32'(in_ready_a), 32'(!m_valid || out_ready_a));
      chk("a_err_dest", 32'(err_dest_a), 32'(m_ed));
      chk("a_err_proto", 32'(err_proto_a), 32'(m_ep));
      chk("a_pkt_count", 32'(pkt_count_a), 32'(m_count));
   endtask

   function automatic logic [31:0] mk_a(input logic [1:0] t, input int d);
      return {t, 28'($urandom), 2'(d)};
   endfunction

   function automatic logic [31:0] mk_b(input logic [1:0] t, input int d);
      return {t, 27'($urandom), 3'(d)};
   endfunction

   task automatic tick_b(input bit rst, input bit vld, input logic [31:0] f,
                         input bit ev, input int eport, input logic [31:0] eflit,
                         input bit eed, input bit eep, input int ecnt);
      reset_b = rst; in_valid_b = vld; in_flit_b = f; out_ready_b = 1'b1;
      @(posedge clk);
      #1;
      chk("b_out_valid", 32'(out_valid_b), 32'(ev));
      if (ev) begin
         chk("b_out_port", 32'(out_port_b), 32'(eport));
         chk("b_out_flit", out_flit_b, eflit);
      end
      chk("b_err_dest", 32'(err_dest_b), 32'(eed));
      chk("b_err_proto", 32'(err_proto_b), 32'(eep));
      chk("b_pkt_count", 32'(pkt_count_b), 32'(ecnt));
   endtask

   initial begin
      logic [31:0] f;
      logic [31:0] body;
      rt_a = '0;
      rt_a[0] = 3'd0; rt_a[1] = 3'd3; rt_a[2] = 3'd2; rt_a[3] = 3'd3;
      rt_b = '0;
      rt_b[0] = 3'd0; rt_b[1] = 3'd3; rt_b[2] = 3'd2;
      rt_b[3] = 3'd3; rt_b[4] = 3'd1; rt_b[5] = 3'd4;
      reset_b = 1'b1; in_valid_b = 1'b0; in_flit_b = '0; out_ready_b = 1'b1;

      // Reset state
      tick_a(1, 0, '0, 1);
      tick_a(1, 0, '0, 1);
      tick_a(0, 0, '0, 1);

      // Head/body/tail to dest 2
      tick_a(0, 1, mk_a(HEAD, 2), 1);
      tick_a(0, 1, mk_a(BODY, 1), 1);
      tick_a(0, 1, mk_a(TAIL, 3), 1);
      tick_a(0, 0, '0, 1);

      // Back-to-back headtails
      tick_a(0, 1, mk_a(HEADTAIL, 1), 1);
      tick_a(0, 1, mk_a(HEADTAIL, 0), 1);
      tick_a(0, 0, '0, 1);

      // Backpressure with a held head
      tick_a(0, 1, mk_a(HEAD, 1), 1);
      body = mk_a(BODY, 2);
      tick_a(0, 1, body, 0);
      tick_a(0, 1, body, 0);
      tick_a(0, 1, body, 0);
      tick_a(0, 1, body, 1);
      tick_a(0, 1, mk_a(TAIL, 0), 1);
      tick_a(0, 0, '0, 1);

      // Table change mid-packet must not affect the packet
      tick_a(0, 1, mk_a(HEAD, 1), 1);
      rt_a[1] = 3'd4;
      tick_a(0, 1, mk_a(BODY, 0), 1);
      tick_a(0, 1, mk_a(TAIL, 0), 1);
      tick_a(0, 1, mk_a(HEADTAIL, 1), 1);
      rt_a[1] = 3'd3;
      tick_a(0, 0, '0, 1);

      // Protocol errors: body in IDLE, head inside an open packet
      tick_a(0, 1, mk_a(BODY, 0), 1);
      tick_a(0, 1, mk_a(HEAD, 2), 1);
      tick_a(0, 1, mk_a(HEAD, 1), 1);
      tick_a(0, 1, mk_a(HEADTAIL, 3), 1);
      tick_a(0, 1, mk_a(TAIL, 0), 1);
      tick_a(0, 0, '0, 1);

      // Reset with a flit held and packet open
      tick_a(0, 1, mk_a(HEAD, 2), 1);
      tick_a(0, 1, mk_a(BODY, 0), 0);
      tick_a(1, 0, '0, 0);
      tick_a(0, 1, mk_a(BODY, 0), 1);
      tick_a(0, 0, '0, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int t;
         t = int'($urandom_range(0, 9));
         if (t < 3)      f = mk_a(BODY, int'($urandom_range(0, 3)));
         else if (t < 5) f = mk_a(HEAD, int'($urandom_range(0, 3)));
         else if (t < 7) f = mk_a(TAIL, int'($urandom_range(0, 3)));
         else            f = mk_a(HEADTAIL, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 15) == 0)
            rt_a[$urandom_range(0, 3)] = 3'($urandom_range(0, 4));
         tick_a($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, f,
                $urandom_range(0, 3) != 0);
      end

      // Out-of-range destinations on the 2x3 instance
      tick_b(1, 0, '0, 0, 0, '0, 0, 0, 0);
      tick_b(0, 0, '0, 0, 0, '0, 0, 0, 0);
      tick_b(0, 1, mk_b(HEAD, 7), 0, 0, '0, 1, 0, 0);
      tick_b(0, 1, mk_b(BODY, 3), 0, 0, '0, 0, 0, 0);
      tick_b(0, 1, mk_b(TAIL, 1), 0, 0, '0, 0, 0, 0);
      tick_b(0, 1, mk_b(HEADTAIL, 6), 0, 0, '0, 1, 0, 0);
      f = mk_b(HEAD, 5);
      tick_b(0, 1, f, 1, 4, f, 0, 0, 1);
      tick_b(0, 1, mk_b(HEAD, 7), 0, 0, '0, 1, 1, 1);
      f = mk_b(HEADTAIL, 4);
      tick_b(0, 1, f, 1, 1, f, 0, 1, 2);
      tick_b(0, 0, '0, 0, 0, '0, 0, 0, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/route_compute.md
Name: route_compute

Overview:
- Route-computation stage of one router input port: sits between the input flit buffer and the switch allocator, and consumes the per-router destination-to-port table.
- On each head flit, looks up the output port for the flit's destination and latches it for the whole packet.
- Tags every flit of the packet with that port and forwards it through a one-deep registered valid/ready stage.
- Drops malformed packets and packets with out-of-range destinations, and reports them on error strobes.

Parameters:
- NUM_ROWS, 2, mesh rows.
- NUM_COLS, 2, mesh columns.
- NUM_OUTPUTS, 5, router ports; 0=local, 1=N, 2=S, 3=E, 4=W.
- FLIT_WIDTH, 32, flit width including the 2-bit type field.
- CNT_WIDTH, 16, width of the routed-packet counter.
- ROUTE_WIDTH, $clog2(NUM_OUTPUTS), port-index width.
- RTR_ADDR_WIDTH, $clog2(NUM_ROWS*NUM_COLS), destination-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- routing_table  in  [0:NUM_ROWS*NUM_COLS-1][ROUTE_WIDTH-1:0]  port index per destination.
- in_flit  in  FLIT_WIDTH  flit from the input buffer.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  stage can accept a flit this cycle.
- out_flit  out  FLIT_WIDTH  registered flit, unmodified.
- out_port  out  ROUTE_WIDTH  output port for out_flit.
- out_valid  out  1  out_flit/out_port are valid.
- out_ready  in  1  switch allocator accepts the flit.
- err_dest  out  1  one-cycle pulse: head flit has destination >= NUM_ROWS*NUM_COLS.
- err_proto  out  1  one-cycle pulse: flit-type sequence violation.
- pkt_count  out  CNT_WIDTH  number of packets routed.

Behaviour:
- Flit format:
  - [FLIT_WIDTH-1:FLIT_WIDTH-2] is the type: 00 body, 01 head, 10 tail, 11 headtail.
  - In head and headtail flits, the destination is [RTR_ADDR_WIDTH-1:0].
- Handshake:
  - in_ready = !out_valid || out_ready, in every state.
  - A flit is accepted when in_valid && in_ready.
  - A flit is delivered when out_valid && out_ready.
  - out_flit, out_port and out_valid are held stable while out_valid && !out_ready.
- Latency: an accepted, forwarded flit appears on out_* the next cycle. Full throughput is one flit per cycle.
- Output register update when a flit is accepted:
  - Forwarded flit: loads out_* and sets out_valid=1.
  - Dropped flit: out_valid becomes 0 if the current output was delivered that cycle, otherwise it is unchanged.
- FSM states: IDLE, ACTIVE, DROP. The route register holds the port for the current packet.
- IDLE:
  - head with valid destination: route <= routing_table[dest]; forward; go to ACTIVE.
  - headtail with valid destination: forward with the looked-up port; stay in IDLE.
  - head with invalid destination: drop; pulse err_dest; go to DROP.
  - headtail with invalid destination: drop; pulse err_dest; stay in IDLE.
  - body or tail: drop; pulse err_proto.
- ACTIVE:
  - body: forward with the route register.
  - tail: forward with the route register; go to IDLE.
  - head or headtail: pulse err_proto, then handle the flit exactly as in IDLE. The previous packet is considered closed.
- DROP:
  - body: dropped silently.
  - tail: dropped silently; go to IDLE.
  - head or headtail: pulse err_proto, then handle as in IDLE.
- Table sampling: routing_table is sampled only at head/headtail acceptance. Table changes mid-packet do not affect that packet.
- pkt_count increments on each forwarded head or headtail and wraps modulo 2^CNT_WIDTH. Dropped packets are not counted.
- err_dest and err_proto can pulse in the same cycle; err_proto=1 and err_dest=1 when a head with a bad destination arrives in ACTIVE.
- Reset values: state=IDLE, route=0, out_valid=0, out_flit=0, out_port=0, err_dest=0, err_proto=0, pkt_count=0. in_ready=1 the cycle after reset.
- Reset mid-packet discards any held flit. The next flit is interpreted in IDLE.

Decomposition:
- Shared package noc_pkg holds:
  - flit_type_e {BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEADTAIL=2'b11};
  - port constants PORT_LOCAL=0, PORT_N=1, PORT_S=2, PORT_E=3, PORT_W=4;
  - flit field position constants.
- Sub-module: none required. The output register is a single always_ff block alongside the FSM.

Test Plan (NUM_ROWS=NUM_COLS=2, routing_table={0,3,2,3}, out_ready=1 unless stated):
- Head dest=2, body, tail on consecutive cycles -> three flits out one cycle later with out_port=2 each; pkt_count=1; state back to IDLE.
- Headtail dest=1, then headtail dest=0 back-to-back -> out_port 3 then 0 on consecutive cycles; pkt_count=2.
- Head dest=1, then out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0; out_flit/out_port=3 held stable; no flit lost after out_ready=1.
- Stimulus: `routing_table` entry 1 changed to 4 after head dest=1 is accepted, then body, then tail. Required response: body and tail still leave on `out_port`=3.
- Body flit in IDLE -> no output, err_proto pulses one cycle. Then head dest=1 arrives in ACTIVE mid-packet -> err_proto pulses, the head is forwarded and pkt_count increments.
- Reset asserted with a flit held and state=ACTIVE -> next cycle out_valid=0, pkt_count=0. A subsequent body flit raises err_proto.
- Out-of-range destination case, exercised with NUM_ROWS=2, NUM_COLS=3 and the address field forced to 7:
  - head dest=7 -> err_dest pulses; no output;
  - the following body and tail are dropped silently.
